// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared FSM state type and supported operand widths for the sequential divider
package seq_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int WIDTH_8  = 8;
    localparam int WIDTH_16 = 16;
    localparam int WIDTH_32 = 32;

    function automatic bit legal_width(int w);
        return (w == WIDTH_8) || (w == WIDTH_16) || (w == WIDTH_32);
    endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one unsigned restoring-division step on a {rem, quo} pair
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < b always holds, so the shifted remainder fits in WIDTH+1 bits and trial's MSB is its sign
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, b};
        rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_n   = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative unsigned divider, one quotient bit per cycle, valid/ready handshakes
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem, step_quo;

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (step_rem_src()),
        .quo   (quo_q),
        .b     (div_q),
        .rem_n (step_rem),
        .quo_n (step_quo)
    );

    function automatic logic [WIDTH-1:0] step_rem_src();
        return rem_q;
    endfunction

    // next-state: latch operands on accept, iterate in CALC, hold the result in DONE
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d   = b;
                    dbz_d   = (b == '0);
                    rem_d   = (b == '0) ? a : '0;
                    quo_d   = (b == '0) ? '1 : a;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = (b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? DONE : CALC;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // state register; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q         = quo_q;
    assign r         = rem_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed vector table plus multi-cycle corner sequences for seq_div at 32 and 8 bits
module tb_seq_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv32, ir32, ov32, or32, z32;
    logic [31:0] a32, b32, q32, r32;
    logic        iv8, ir8, ov8, or8, z8;
    logic [7:0]  a8, b8, q8, r8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .out_valid(ov32), .out_ready(or32), .q(q32), .r(r32), .dbz(z32)
    );

    seq_div #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .q(q8), .r(r8), .dbz(z8)
    );

    typedef struct {
        bit          w8;
        logic [31:0] a, b, q, r;
        logic        z;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic get_ov(bit w8);  return w8 ? ov8 : ov32; endfunction
    function automatic logic get_ir(bit w8);  return w8 ? ir8 : ir32; endfunction
    function automatic logic get_z(bit w8);   return w8 ? z8 : z32; endfunction
    function automatic logic [31:0] get_q(bit w8); return w8 ? {24'b0, q8} : q32; endfunction
    function automatic logic [31:0] get_r(bit w8); return w8 ? {24'b0, r8} : r32; endfunction

    task automatic drive(input bit w8, input logic v, input logic [31:0] av, input logic [31:0] bv);
        if (w8) begin iv8 = v; a8 = av[7:0]; b8 = bv[7:0]; end
        else begin iv32 = v; a32 = av; b32 = bv; end
    endtask

    task automatic set_ordy(input bit w8, input logic v);
        if (w8) or8 = v; else or32 = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        set_ordy(0, 0);
        set_ordy(1, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Starts in IDLE, #1 after an edge; returns there after the result is consumed
    task automatic run(input bit w8, input logic [31:0] av, input logic [31:0] bv, input int hold,
                       output logic [31:0] qo, output logic [31:0] ro, output logic zo, output int lat);
        logic busy_ok;
        drive(w8, 1, av, bv);
        @(posedge clk); #1;
        lat = 1;
        busy_ok = 1'b1;
        while (!get_ov(w8) && lat < 64) begin
            if (get_ir(w8)) busy_ok = 1'b0;
            drive(w8, 1'($urandom_range(0, 1)), $urandom, $urandom);
            @(posedge clk); #1;
            lat++;
        end
        drive(w8, 0, $urandom, $urandom);
        qo = get_q(w8);
        ro = get_r(w8);
        zo = get_z(w8);
        chk("in_ready low while busy", {31'b0, busy_ok}, 32'd1);
        if (!get_ov(w8)) begin
            chk("out_valid timeout", 32'd0, 32'd1);
            do_reset();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            drive(w8, 1'($urandom_range(0, 1)), $urandom, $urandom);
            @(posedge clk); #1;
            chk("held q", get_q(w8), qo);
            chk("held r", get_r(w8), ro);
            chk("held in_ready", {31'b0, get_ir(w8)}, 32'd0);
            chk("held out_valid", {31'b0, get_ov(w8)}, 32'd1);
        end
        drive(w8, 0, $urandom, $urandom);
        set_ordy(w8, 1);
        chk("in_ready before release", {31'b0, get_ir(w8)}, 32'd0);
        @(posedge clk); #1;
        set_ordy(w8, 0);
        chk("in_ready after release", {31'b0, get_ir(w8)}, 32'd1);
        chk("out_valid after release", {31'b0, get_ov(w8)}, 32'd0);
    endtask

    initial begin
        logic [31:0] qv, rv, av, bv, mask, eq, er;
        logic        zv;
        int          lat;
        bit          w8;
        bit          saw_ov;

        tbl[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33, 0};
        tbl[1]  = '{0, 32'hDEADBEEF,   32'd0,          32'hFFFFFFFF,   32'hDEADBEEF,   1'b1, 1,  0};
        tbl[2]  = '{0, 32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0, 33, 5};
        tbl[3]  = '{0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33, 0};
        tbl[4]  = '{0, 32'd12345,      32'd12345,      32'd1,          32'd0,          1'b0, 33, 1};
        tbl[5]  = '{0, 32'hFFFFFFFF,   32'd3,          32'h55555555,   32'd0,          1'b0, 33, 0};
        tbl[6]  = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 33, 0};
        tbl[7]  = '{0, 32'hFFFFFFFF,   32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 33, 0};
        tbl[8]  = '{1, 32'd255,        32'd1,          32'd255,        32'd0,          1'b0, 9,  0};
        tbl[9]  = '{1, 32'd5,          32'd200,        32'd0,          32'd5,          1'b0, 9,  2};
        tbl[10] = '{1, 32'd128,        32'd128,        32'd1,          32'd0,          1'b0, 9,  0};
        tbl[11] = '{1, 32'd200,        32'd7,          32'd28,         32'd4,          1'b0, 9,  0};
        tbl[12] = '{1, 32'd0,          32'd0,          32'd255,        32'd0,          1'b1, 1,  3};

        do_reset();
        chk("rst in_ready32", {31'b0, ir32}, 32'd1);
        chk("rst out_valid32", {31'b0, ov32}, 32'd0);
        chk("rst q32", q32, 32'd0);
        chk("rst r32", r32, 32'd0);
        chk("rst dbz32", {31'b0, z32}, 32'd0);
        chk("rst in_ready8", {31'b0, ir8}, 32'd1);
        chk("rst q8", {24'b0, q8}, 32'd0);

        foreach (tbl[i]) begin
            run(tbl[i].w8, tbl[i].a, tbl[i].b, tbl[i].hold, qv, rv, zv, lat);
            chk($sformatf("vec%0d q", i), qv, tbl[i].q);
            chk($sformatf("vec%0d r", i), rv, tbl[i].r);
            chk($sformatf("vec%0d dbz", i), {31'b0, zv}, {31'b0, tbl[i].z});
            chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
        end

        // reset on the tenth CALC cycle discards the operation
        drive(0, 1, 32'd1000, 32'd3);
        @(posedge clk); #1;
        drive(0, 0, 0, 0);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midcalc rst in_ready", {31'b0, ir32}, 32'd1);
        chk("midcalc rst out_valid", {31'b0, ov32}, 32'd0);
        chk("midcalc rst q", q32, 32'd0);
        chk("midcalc rst r", r32, 32'd0);
        saw_ov = 1'b0;
        repeat (40) begin @(posedge clk); #1; saw_ov |= ov32; end
        chk("midcalc no out_valid", {31'b0, saw_ov}, 32'd0);
        run(0, 32'd9, 32'd3, 0, qv, rv, zv, lat);
        chk("post rst q", qv, 32'd3);
        chk("post rst r", rv, 32'd0);

        // reset beats DONE with out_ready, clearing the held result
        drive(1, 1, 32'd7, 32'd0);
        @(posedge clk); #1;
        drive(1, 0, 0, 0);
        chk("dbz8 done", {31'b0, ov8}, 32'd1);
        or8 = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("done rst in_ready", {31'b0, ir8}, 32'd1);
        chk("done rst q", {24'b0, q8}, 32'd0);
        chk("done rst r", {24'b0, r8}, 32'd0);
        chk("done rst dbz", {31'b0, z8}, 32'd0);

        // no accept while reset is sampled
        drive(1, 1, 32'd10, 32'd2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        chk("rst blocks accept", {31'b0, ir8}, 32'd1);
        @(posedge clk); #1;
        chk("rst blocks accept later", {31'b0, ir8 & ~ov8}, 32'd1);

        // random operands against a behavioural model, operands scrambled while busy
        for (int i = 0; i < 300; i++) begin
            w8   = (i % 2) == 1;
            mask = w8 ? 32'hFF : 32'hFFFFFFFF;
            av   = $urandom & mask;
            bv   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31)) & mask;
            eq   = (bv == 0) ? mask : av / bv;
            er   = (bv == 0) ? av : av % bv;
            run(w8, av, bv, $urandom_range(0, 2), qv, rv, zv, lat);
            chk($sformatf("rand q %h/%h", av, bv), qv, eq);
            chk($sformatf("rand r %h/%h", av, bv), rv, er);
            chk($sformatf("rand dbz %h/%h", av, bv), {31'b0, zv}, {31'b0, bv == 0});
            chk($sformatf("rand lat %h/%h", av, bv), lat, (bv == 0) ? 1 : (w8 ? 9 : 33));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
